execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_if.sv | 36 +++
 rtl/execute_stage.sv | 140 ++++++++++++++
 tb/tb_execute_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Decode-to-execute handshake and the execute-stage result bus.
interface execute_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] Instruction;
  logic [63:0] PC;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic [63:0] SignExtImm;
  logic        ALUSrc;
  logic [3:0]  ALUCtl;
  logic        B, BZ, BNZ, MemRead, MemWrite, MemToReg, RegWrite;

  logic [31:0] Instruction_o;
  logic [63:0] branchAddress;
  logic [63:0] Results;
  logic [63:0] Data2;
  logic        zero;
  logic        B_o, BZ_o, BNZ_o, MemRead_o, MemWrite_o, MemToReg_o, RegWrite_o;
  logic        out_valid;

  modport master (
    output in_valid, flush, Instruction, PC, ReadData1, ReadData2, SignExtImm,
           ALUSrc, ALUCtl, B, BZ, BNZ, MemRead, MemWrite, MemToReg, RegWrite,
    input  in_ready, Instruction_o, branchAddress, Results, Data2, zero,
           B_o, BZ_o, BNZ_o, MemRead_o, MemWrite_o, MemToReg_o, RegWrite_o, out_valid
  );

  modport slave (
    input  in_valid, flush, Instruction, PC, ReadData1, ReadData2, SignExtImm,
           ALUSrc, ALUCtl, B, BZ, BNZ, MemRead, MemWrite, MemToReg, RegWrite,
    output in_ready, Instruction_o, branchAddress, Results, Data2, zero,
           B_o, BZ_o, BNZ_o, MemRead_o, MemWrite_o, MemToReg_o, RegWrite_o, out_valid
  );
endinterface

// File: rtl/execute_stage.sv
// Pipeline execute stage: single-cycle ALU, branch-target adder and a
// 64-iteration shift-add multiplier that stalls the decode stage while busy.
module execute_stage (
  input  logic            clk,
  input  logic            reset_n,
  execute_stage_if.slave  ex
);
  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MUL  = 4'b1000;

  state_t      r_state, w_state_next;
  logic [5:0]  r_count;
  logic [63:0] r_mcand, r_mplr, r_acc;

  // Fields of an in-flight multiply, held until its result is emitted.
  logic [31:0] r_cap_instr;
  logic [63:0] r_cap_br, r_cap_data2;
  logic [6:0]  r_cap_ctl;

  logic [31:0] r_instr_o;
  logic [63:0] r_br_o, r_results, r_data2_o;
  logic        r_zero, r_out_valid;
  logic [6:0]  r_ctl_o;

  logic [63:0] w_opb, w_alu, w_br, w_acc_next;
  logic [6:0]  w_ctl_in;
  logic        w_accept, w_is_mul, w_mul_done;

  assign w_opb      = ex.ALUSrc ? ex.SignExtImm : ex.ReadData2;
  assign w_br       = ex.PC + (ex.SignExtImm << 2);
  assign w_ctl_in   = {ex.B, ex.BZ, ex.BNZ, ex.MemRead, ex.MemWrite, ex.MemToReg, ex.RegWrite};
  assign w_is_mul   = (ex.ALUCtl == ALU_MUL);
  assign w_accept   = ex.in_valid && (r_state == IDLE) && !ex.flush;
  assign w_acc_next = r_acc + (r_mplr[0] ? r_mcand : '0);
  assign w_mul_done = (r_state == MUL_BUSY) && (r_count == 6'd63);

  always_comb begin
    w_alu = '0;
    case (ex.ALUCtl)
      ALU_AND:  w_alu = ex.ReadData1 & w_opb;
      ALU_ORR:  w_alu = ex.ReadData1 | w_opb;
      ALU_ADD:  w_alu = ex.ReadData1 + w_opb;
      ALU_SUB:  w_alu = ex.ReadData1 - w_opb;
      ALU_PASS: w_alu = w_opb;
      ALU_NOR:  w_alu = ~(ex.ReadData1 | w_opb);
      default:  w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_accept && w_is_mul) w_state_next = MUL_BUSY;
      MUL_BUSY: if (ex.flush || w_mul_done) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_mcand     <= '0;
      r_mplr      <= '0;
      r_acc       <= '0;
      r_cap_instr <= '0;
      r_cap_br    <= '0;
      r_cap_data2 <= '0;
      r_cap_ctl   <= '0;
      r_instr_o   <= '0;
      r_br_o      <= '0;
      r_results   <= '0;
      r_data2_o   <= '0;
      r_zero      <= 1'b1;
      r_ctl_o     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // Every edge is a bubble unless a result is registered below.
      r_out_valid <= 1'b0;
      r_ctl_o     <= '0;
      if (ex.flush) begin
        r_count <= '0;
      end else if (w_accept) begin
        if (w_is_mul) begin
          r_count     <= '0;
          r_acc       <= '0;
          r_mcand     <= ex.ReadData1;
          r_mplr      <= w_opb;
          r_cap_instr <= ex.Instruction;
          r_cap_br    <= w_br;
          r_cap_data2 <= ex.ReadData2;
          r_cap_ctl   <= w_ctl_in;
        end else begin
          r_instr_o   <= ex.Instruction;
          r_br_o      <= w_br;
          r_results   <= w_alu;
          r_data2_o   <= ex.ReadData2;
          r_zero      <= (w_alu == '0);
          r_ctl_o     <= w_ctl_in;
          r_out_valid <= 1'b1;
        end
      end else if (r_state == MUL_BUSY) begin
        r_acc   <= w_acc_next;
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
        r_count <= r_count + 6'd1;
        if (w_mul_done) begin
          r_instr_o   <= r_cap_instr;
          r_br_o      <= r_cap_br;
          r_results   <= w_acc_next;
          r_data2_o   <= r_cap_data2;
          r_zero      <= (w_acc_next == '0);
          r_ctl_o     <= r_cap_ctl;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign ex.in_ready      = (r_state == IDLE);
  assign ex.Instruction_o = r_instr_o;
  assign ex.branchAddress = r_br_o;
  assign ex.Results       = r_results;
  assign ex.Data2         = r_data2_o;
  assign ex.zero          = r_zero;
  assign ex.out_valid     = r_out_valid;
  assign {ex.B_o, ex.BZ_o, ex.BNZ_o, ex.MemRead_o, ex.MemWrite_o, ex.MemToReg_o,
          ex.RegWrite_o} = r_ctl_o;
endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  execute_stage_if ifc ();
  execute_stage dut (.clk(clk), .reset_n(reset_n), .ex(ifc));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc, a, b, imm;
    logic        alusrc;
    logic [3:0]  ctl;
    logic [6:0]  cb;
  } op_t;

  logic [63:0] last_res, last_br, last_d2;
  logic [31:0] last_instr;
  logic        last_zero;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] model_result(input op_t op);
    logic [63:0] b;
    b = op.alusrc ? op.imm : op.b;
    case (op.ctl)
      4'd0:    return op.a & b;
      4'd1:    return op.a | b;
      4'd2:    return op.a + b;
      4'd6:    return op.a - b;
      4'd7:    return b;
      4'd12:   return ~(op.a | b);
      4'd8:    return op.a * b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [6:0] ctl_out();
    return {ifc.B_o, ifc.BZ_o, ifc.BNZ_o, ifc.MemRead_o, ifc.MemWrite_o, ifc.MemToReg_o,
            ifc.RegWrite_o};
  endfunction

  function automatic op_t rand_op();
    op_t op;
    op.instr  = $urandom;
    op.pc     = rnd64();
    op.a      = rnd64();
    op.b      = ($urandom_range(0, 7) == 0) ? op.a : rnd64();
    op.imm    = rnd64();
    op.alusrc = 1'($urandom_range(0, 1));
    op.cb     = 7'($urandom_range(0, 127));
    case ($urandom_range(0, 9))
      0: op.ctl = 4'd0;
      1: op.ctl = 4'd1;
      2: op.ctl = 4'd2;
      3: op.ctl = 4'd6;
      4: op.ctl = 4'd7;
      5: op.ctl = 4'd12;
      6: op.ctl = 4'd8;
      7: op.ctl = 4'd9;
      8: op.ctl = 4'd2;
      default: op.ctl = 4'd6;
    endcase
    return op;
  endfunction

  function automatic op_t mk(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] imm, input logic alusrc,
                             input logic [63:0] pc, input logic [6:0] cb);
    op_t op;
    op.instr = $urandom; op.pc = pc; op.a = a; op.b = b; op.imm = imm;
    op.alusrc = alusrc; op.ctl = ctl; op.cb = cb;
    return op;
  endfunction

  task automatic drive(input op_t op);
    ifc.Instruction = op.instr;
    ifc.PC          = op.pc;
    ifc.ReadData1   = op.a;
    ifc.ReadData2   = op.b;
    ifc.SignExtImm  = op.imm;
    ifc.ALUSrc      = op.alusrc;
    ifc.ALUCtl      = op.ctl;
    {ifc.B, ifc.BZ, ifc.BNZ, ifc.MemRead, ifc.MemWrite, ifc.MemToReg, ifc.RegWrite} = op.cb;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 64'(ifc.out_valid), 64'd0);
    check({tag, "_ready"}, 64'(ifc.in_ready), 64'd1);
    check({tag, "_ctl"}, 64'(ctl_out()), 64'd0);
    check({tag, "_res"}, ifc.Results, 64'd0);
    check({tag, "_br"}, ifc.branchAddress, 64'd0);
    check({tag, "_d2"}, ifc.Data2, 64'd0);
    check({tag, "_instr"}, 64'(ifc.Instruction_o), 64'd0);
    check({tag, "_zero"}, 64'(ifc.zero), 64'd1);
    last_res = '0; last_br = '0; last_d2 = '0; last_instr = '0; last_zero = 1'b1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_bvalid"}, 64'(ifc.out_valid), 64'd0);
    check({tag, "_bctl"}, 64'(ctl_out()), 64'd0);
    check({tag, "_bres"}, ifc.Results, last_res);
    check({tag, "_bbr"}, ifc.branchAddress, last_br);
    check({tag, "_bd2"}, ifc.Data2, last_d2);
    check({tag, "_binstr"}, 64'(ifc.Instruction_o), 64'(last_instr));
    check({tag, "_bzero"}, 64'(ifc.zero), 64'(last_zero));
  endtask

  task automatic check_result(input op_t op, input string tag);
    logic [63:0] res;
    res = model_result(op);
    check({tag, "_valid"}, 64'(ifc.out_valid), 64'd1);
    check({tag, "_ready"}, 64'(ifc.in_ready), 64'd1);
    check({tag, "_res"}, ifc.Results, res);
    check({tag, "_zero"}, 64'(ifc.zero), 64'(res == 64'd0));
    check({tag, "_br"}, ifc.branchAddress, op.pc + op.imm * 64'd4);
    check({tag, "_d2"}, ifc.Data2, op.b);
    check({tag, "_instr"}, 64'(ifc.Instruction_o), 64'(op.instr));
    check({tag, "_ctl"}, 64'(ctl_out()), 64'(op.cb));
    last_res = res; last_br = op.pc + op.imm * 64'd4; last_d2 = op.b;
    last_instr = op.instr; last_zero = (res == 64'd0);
  endtask

  // Present one op, wait for its result (bounded), check it and the bubble after it.
  task automatic do_op(input op_t op, input string tag);
    int n, bad;
    @(negedge clk);
    drive(op);
    ifc.flush    = 1'b0;
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    drive(rand_op());
    if (op.ctl == 4'd8) begin
      n = 0; bad = 0;
      while (ifc.in_ready == 1'b0 && n < 200) begin
        if (ifc.out_valid) bad++;
        @(posedge clk); #1;
        n++;
      end
      check({tag, "_lat"}, 64'(n), 64'd64);
      check({tag, "_busyvalid"}, 64'(bad), 64'd0);
    end
    check_result(op, tag);
    @(posedge clk); #1;
    check_bubble(tag);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ifc.out_valid) bad++;
    end
    check({tag, "_noresult"}, 64'(bad), 64'd0);
  endtask

  initial begin
    op_t op;
    reset_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.flush = 1'b0;
    drive(rand_op());
    repeat (3) @(posedge clk);
    #1 check_reset("rst");
    @(negedge clk) reset_n = 1'b1;

    do_op(mk(4'd2, 64'd5, rnd64(), 64'd3, 1'b1, rnd64(), 7'h41), "add");
    check("add_res8", ifc.Results, 64'd8);
    do_op(mk(4'd6, 64'h1234, 64'h1234, rnd64(), 1'b0, rnd64(), 7'h00), "sub");
    check("sub_zero", 64'(ifc.zero), 64'd1);
    do_op(mk(4'd7, rnd64(), 64'd0, rnd64(), 1'b0, rnd64(), 7'b0100000), "cbz");
    do_op(mk(4'd2, rnd64(), rnd64(), 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h100, 7'h7F), "brneg");
    check("brneg_addr", ifc.branchAddress, 64'hF0);
    do_op(mk(4'd2, rnd64(), rnd64(), 64'h3FFF_FFFF_FFFF_FFFF, 1'b0, 64'd8, 7'h10), "brwrap");
    check("brwrap_addr", ifc.branchAddress, 64'd4);
    do_op(mk(4'd8, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, rnd64(), 1'b0, rnd64(), 7'h55), "mul");
    check("mul_res", ifc.Results, 64'hFFFF_FFFF_FFFF_FFF9);
    do_op(mk(4'd3, rnd64(), rnd64(), rnd64(), 1'b1, rnd64(), 7'h7F), "unlisted");

    // Flush with a valid op in IDLE: never accepted.
    @(negedge clk);
    drive(rand_op());
    ifc.in_valid = 1'b1; ifc.flush = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0; ifc.flush = 1'b0;
    check_bubble("flushidle");
    watch_quiet("flushidle", 3);

    // Flush on cycle 10 of a multiply.
    op = mk(4'd8, rnd64(), rnd64(), rnd64(), 1'b0, rnd64(), 7'h7F);
    @(negedge clk); drive(op); ifc.in_valid = 1'b1;
    @(posedge clk); #1 ifc.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk) ifc.flush = 1'b1;
    @(posedge clk); #1 ifc.flush = 1'b0;
    check("mulflush_ready", 64'(ifc.in_ready), 64'd1);
    check_bubble("mulflush");
    watch_quiet("mulflush", 80);
    do_op(mk(4'd2, rnd64(), rnd64(), rnd64(), 1'b1, rnd64(), 7'h03), "postflush");

    // Reset during a multiply with in_valid held high.
    op = mk(4'd8, rnd64(), rnd64(), rnd64(), 1'b0, rnd64(), 7'h7F);
    @(negedge clk); drive(op); ifc.in_valid = 1'b1;
    @(posedge clk); #1 ifc.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0; ifc.in_valid = 1'b1;
    drive(mk(4'd2, 64'd1, 64'd1, 64'd1, 1'b0, 64'd1, 7'h7F));
    @(posedge clk); #1;
    check_reset("mulrst");
    @(negedge clk);
    reset_n = 1'b1; ifc.in_valid = 1'b0;
    watch_quiet("mulrst", 80);

    for (int i = 0; i < 50; i++) begin
      op = rand_op();
      do_op(op, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
